layer_compositor: RTL and testbench
===================================

// Module: layer_compositor
// PURPOSE
//  - Parametrised pixel compositor between the sprite blocks and hdmi_transmit.
//  - Replaces the fixed alien>paddle>bullet ternary chain.
//  - Adds N layers, runtime-programmable per-layer priority (frame-synchronous),
//    a full-screen overlay override (game over) and per-frame pairwise collision flags.
//  - Two-cycle registered pipeline; caller delays hpos/vpos/sync to match.
// PARAMETERS
//  NUM_LAYERS  5  number of sprite layers (2..8)
//  COLOR_W     8  bits per colour channel
//  BLEND_MODE  0  0 = priority select; 1 = legacy bitwise OR of all active layers
//  RANK_W = $clog2(NUM_LAYERS), derived localparam, not overridable
// PORTS
//  pixel_clk     in   1                      pixel clock; all logic on rising edge
//  rst_n         in   1                      asynchronous, active-low reset
//  fsync         in   1                      frame-sync pulse, 1 cycle, start of frame
//  active_in     in   1                      active video region
//  layer_active  in   NUM_LAYERS             bit i: layer i opaque at this pixel
//  layer_pixel   in   NUM_LAYERS*3*COLOR_W   layer i RGB at [i*3*COLOR_W +: 3*COLOR_W], {B,G,R}, R in LSBs
//  ovl_en        in   1                      overlay replaces all layers this pixel
//  ovl_pixel     in   3*COLOR_W              overlay RGB, same packing
//  prio_wr_en    in   1                      write a shadow rank
//  prio_wr_idx   in   RANK_W                 layer index to write; idx>=NUM_LAYERS ignored
//  prio_wr_rank  in   RANK_W                 rank, 0 = front-most
//  pixel_out     out  3*COLOR_W              composited RGB, 2-cycle latency
//  active_out    out  1                      active_in delayed 2 cycles
//  coll_flags    out  NUM_LAYERS*NUM_LAYERS  bit i*N+j: layers i,j overlapped last frame
//  coll_valid    out  1                      1-cycle pulse when coll_flags updates
// BEHAVIOUR
//  Reset (rst_n=0, async assert, sync deassert at the rank registers):
//   - pixel_out=0, active_out=0, coll_flags=0, coll_valid=0, accumulator=0.
//   - live rank[i] = shadow rank[i] = i (layer 0 in front).
//  Pipeline:
//   - S1 registers all inputs and computes winner = active layer of lowest live rank.
//   - Equal ranks: lower index wins. No layer active: winner none.
//   - S2 registers pixel_out:
//       !active_in -> 0
//       else ovl_en -> ovl_pixel
//       else winner none -> 0
//       else layer_pixel[winner]
//   - BLEND_MODE=1 replaces the winner select with the OR of all active layers' pixels.
//   - Overlay and blanking rules are unchanged in BLEND_MODE=1.
//   - Overlay wins even when no layer is active.
//   - Layer colour is never used as transparency key; layer_active alone decides opacity.
//  Priority:
//   - prio_wr_en writes the shadow rank on the next edge.
//   - Live ranks copy from shadow on the edge where fsync=1.
//   - A write in the fsync cycle reaches shadow only; it goes live at the following fsync.
//   - Live ranks never change mid-frame.
//  Collision:
//   - When S1 active_in=1 and S1 layer_active has >=2 bits set, OR every pair (i,j), i!=j,
//     into acc[i*N+j] and acc[j*N+i]. Diagonal is always 0.
//   - ovl_en does not mask collision accumulation.
//   - S1 fsync=1: coll_flags <= acc | (this cycle's contribution); acc <= 0;
//     coll_valid=1 for that one following cycle.
//   - Back-to-back fsync: second update reports only the pairs seen since the first.
//   - First fsync after reset reports the partial frame.
//   - Reset mid-frame discards acc; no coll_valid until the next fsync.
//  Width: all selects are pure muxes (no arithmetic on colour); rank compare is unsigned RANK_W.
// TESTING
//  1. Reset, N=5. L2 and L4 active with distinct colours, active_in=1
//     -> pixel_out = L2 colour exactly 2 cycles later; active_out follows.
//  2. prio_wr idx=4 rank=0 mid-frame -> output unchanged until after fsync,
//     then L4 colour; idx=7 write ignored.
//  3. ovl_en=1, ovl_pixel=24'hFF0000, no layers active -> pixel_out=24'hFF0000;
//     with active_in=0 -> 0.
//  4. L0&L3 overlap at one pixel, then fsync -> coll_valid one cycle;
//     coll_flags bits 3 and 15 set, all others 0; next frame without overlap -> 0.
//  5. BLEND_MODE=1: L0=24'h0000F0 and L1=24'h00000F, both active -> 24'h0000FF.
//  6. rst_n low mid-frame after overlaps -> all outputs 0 immediately;
//     next fsync -> coll_flags=0, ranks back to identity.

Source files
------------

// File: rtl/layer_compositor.sv
// Layer compositor: selects the front-most opaque sprite layer (or a full-screen overlay)
// through a two-cycle pipeline, with frame-synchronous ranks and per-frame collision flags.
`timescale 1ns/1ps
module layer_compositor #(
  parameter int NUM_LAYERS = 5,
  parameter int COLOR_W    = 8,
  parameter int BLEND_MODE = 0,
  localparam int RANK_W    = $clog2(NUM_LAYERS)
) (
  input  logic                              pixel_clk,
  input  logic                              rst_n,
  input  logic                              fsync,
  input  logic                              active_in,
  input  logic [NUM_LAYERS-1:0]             layer_active,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0]   layer_pixel,
  input  logic                              ovl_en,
  input  logic [3*COLOR_W-1:0]              ovl_pixel,
  input  logic                              prio_wr_en,
  input  logic [RANK_W-1:0]                 prio_wr_idx,
  input  logic [RANK_W-1:0]                 prio_wr_rank,
  output logic [3*COLOR_W-1:0]              pixel_out,
  output logic                              active_out,
  output logic [NUM_LAYERS*NUM_LAYERS-1:0]  coll_flags,
  output logic                              coll_valid
);

  localparam int PIX_W  = 3 * COLOR_W;
  localparam int PAIR_W = NUM_LAYERS * NUM_LAYERS;

  logic [1:0]                  rank_rst_q;
  logic                        rank_rst_n_s;
  logic [RANK_W-1:0]           shadow_q [NUM_LAYERS];
  logic [RANK_W-1:0]           live_q   [NUM_LAYERS];

  logic                        active_q;
  logic                        fsync_q;
  logic [NUM_LAYERS-1:0]       layer_active_q;
  logic [NUM_LAYERS*PIX_W-1:0] layer_pixel_q;
  logic                        ovl_en_q;
  logic [PIX_W-1:0]            ovl_pixel_q;

  logic [NUM_LAYERS-1:0]       take_s;
  logic                        win_found_s;
  logic [RANK_W-1:0]           win_rank_s;
  logic [PIX_W-1:0]            win_pix_s;
  logic [PIX_W-1:0]            or_pix_s;
  logic [PIX_W-1:0]            mix_s;
  logic [PIX_W-1:0]            pixel_d;
  logic [PAIR_W-1:0]           pair_s;
  logic [PAIR_W-1:0]           acc_q;

  // Rank registers see reset asserted asynchronously but released on a clock edge.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      rank_rst_q <= 2'b00;
    end else begin
      rank_rst_q <= {rank_rst_q[0], 1'b1};
    end
  end

  assign rank_rst_n_s = rank_rst_q[1];

  always_ff @(posedge pixel_clk or negedge rank_rst_n_s) begin
    if (!rank_rst_n_s) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        shadow_q[i] <= RANK_W'(i);
        live_q[i]   <= RANK_W'(i);
      end
    end else begin
      if (prio_wr_en && (int'(prio_wr_idx) < NUM_LAYERS)) begin
        shadow_q[prio_wr_idx] <= prio_wr_rank;
      end
      // live copies the pre-write shadow, so a write in the fsync cycle waits a frame
      if (fsync) begin
        live_q <= shadow_q;
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q       <= 1'b0;
      fsync_q        <= 1'b0;
      layer_active_q <= '0;
      layer_pixel_q  <= '0;
      ovl_en_q       <= 1'b0;
      ovl_pixel_q    <= '0;
    end else begin
      active_q       <= active_in;
      fsync_q        <= fsync;
      layer_active_q <= layer_active;
      layer_pixel_q  <= layer_pixel;
      ovl_en_q       <= ovl_en;
      ovl_pixel_q    <= ovl_pixel;
    end
  end

  // Strict less-than keeps the lower index on equal ranks.
  always_comb begin
    take_s      = '0;
    win_found_s = 1'b0;
    win_rank_s  = '0;
    win_pix_s   = '0;
    or_pix_s    = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      take_s[i]   = layer_active_q[i] & (~win_found_s | (live_q[i] < win_rank_s));
      win_found_s = win_found_s | take_s[i];
      win_rank_s  = take_s[i] ? live_q[i] : win_rank_s;
      win_pix_s   = take_s[i] ? layer_pixel_q[i*PIX_W +: PIX_W] : win_pix_s;
      or_pix_s    = or_pix_s | (layer_active_q[i] ? layer_pixel_q[i*PIX_W +: PIX_W] : {PIX_W{1'b0}});
    end
  end

  assign mix_s = (BLEND_MODE != 0) ? or_pix_s : win_pix_s;

  always_comb begin
    pixel_d = '0;
    if (!active_q) begin
      pixel_d = '0;
    end else if (ovl_en_q) begin
      pixel_d = ovl_pixel_q;
    end else if (!win_found_s) begin
      pixel_d = '0;
    end else begin
      pixel_d = mix_s;
    end
  end

  always_comb begin
    pair_s = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      for (int j = 0; j < NUM_LAYERS; j++) begin
        pair_s[i*NUM_LAYERS+j] = active_q & layer_active_q[i] & layer_active_q[j] & (i != j);
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_out  <= '0;
      active_out <= 1'b0;
      coll_flags <= '0;
      coll_valid <= 1'b0;
      acc_q      <= '0;
    end else begin
      pixel_out  <= pixel_d;
      active_out <= active_q;
      // the fsync pixel's own overlaps belong to the frame being reported
      if (fsync_q) begin
        coll_flags <= acc_q | pair_s;
        acc_q      <= '0;
        coll_valid <= 1'b1;
      end else begin
        acc_q      <= acc_q | pair_s;
        coll_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: rank-scan reference model compared every cycle against a
// priority-select and a blend-mode instance, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_layer_compositor;

  localparam int N  = 5;
  localparam int CW = 8;
  localparam int PW = 3 * CW;
  localparam int RW = 3;

  localparam logic [PW-1:0] C0 = 24'h0000F0;
  localparam logic [PW-1:0] C1 = 24'h00000F;
  localparam logic [PW-1:0] C2 = 24'h00AA00;
  localparam logic [PW-1:0] C3 = 24'h330000;
  localparam logic [PW-1:0] C4 = 24'hC0C0C0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, fsync, active_in, ovl_en, prio_wr_en;
  logic [N-1:0]    layer_active;
  logic [N*PW-1:0] layer_pixel;
  logic [PW-1:0]   ovl_pixel;
  logic [RW-1:0]   prio_wr_idx, prio_wr_rank;
  logic [PW-1:0]   pixel_out, pixel_out_b;
  logic            active_out, active_out_b, coll_valid, coll_valid_b;
  logic [N*N-1:0]  coll_flags, coll_flags_b;

  int checks = 0;
  int failures = 0;

  layer_compositor #(.NUM_LAYERS(N), .COLOR_W(CW), .BLEND_MODE(0)) dut (
    .pixel_clk(clk), .rst_n(rst_n), .fsync(fsync), .active_in(active_in),
    .layer_active(layer_active), .layer_pixel(layer_pixel), .ovl_en(ovl_en),
    .ovl_pixel(ovl_pixel), .prio_wr_en(prio_wr_en), .prio_wr_idx(prio_wr_idx),
    .prio_wr_rank(prio_wr_rank), .pixel_out(pixel_out), .active_out(active_out),
    .coll_flags(coll_flags), .coll_valid(coll_valid));

  layer_compositor #(.NUM_LAYERS(N), .COLOR_W(CW), .BLEND_MODE(1)) dut_blend (
    .pixel_clk(clk), .rst_n(rst_n), .fsync(fsync), .active_in(active_in),
    .layer_active(layer_active), .layer_pixel(layer_pixel), .ovl_en(ovl_en),
    .ovl_pixel(ovl_pixel), .prio_wr_en(prio_wr_en), .prio_wr_idx(prio_wr_idx),
    .prio_wr_rank(prio_wr_rank), .pixel_out(pixel_out_b), .active_out(active_out_b),
    .coll_flags(coll_flags_b), .coll_valid(coll_valid_b));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // reference model state
  int              m_live[N];
  int              m_shadow[N];
  logic            m_s1_act, m_s1_fs, m_s1_ovl;
  logic [N-1:0]    m_s1_la;
  logic [N*PW-1:0] m_s1_lp;
  logic [PW-1:0]   m_s1_op;
  logic [PW-1:0]   m_pix, m_pixb;
  logic            m_act, m_cv;
  logic [N*N-1:0]  m_acc, m_flags;

  // front-most = first active layer found scanning ranks upward, indices upward
  function automatic logic [PW-1:0] expect_pix(input bit blend);
    logic [PW-1:0] r;
    r = '0;
    if (!m_s1_act) return '0;
    if (m_s1_ovl) return m_s1_op;
    if (blend) begin
      for (int i = 0; i < N; i++) if (m_s1_la[i]) r = r | m_s1_lp[i*PW +: PW];
      return r;
    end
    for (int rk = 0; rk < (1 << RW); rk++)
      for (int i = 0; i < N; i++)
        if (m_s1_la[i] && m_live[i] == rk) return m_s1_lp[i*PW +: PW];
    return '0;
  endfunction

  function automatic logic [N*N-1:0] pairs(input logic act, input logic [N-1:0] la);
    logic [N*N-1:0] r;
    r = '0;
    if (act)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (i != j && la[i] && la[j]) r[i*N+j] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_live[i]   <= i;
        m_shadow[i] <= i;
      end
      m_s1_act <= 1'b0; m_s1_fs <= 1'b0; m_s1_ovl <= 1'b0;
      m_s1_la <= '0; m_s1_lp <= '0; m_s1_op <= '0;
      m_pix <= '0; m_pixb <= '0; m_act <= 1'b0; m_cv <= 1'b0;
      m_acc <= '0; m_flags <= '0;
    end else begin
      m_pix  <= expect_pix(1'b0);
      m_pixb <= expect_pix(1'b1);
      m_act  <= m_s1_act;
      if (m_s1_fs) begin
        m_flags <= m_acc | pairs(m_s1_act, m_s1_la);
        m_acc   <= '0;
        m_cv    <= 1'b1;
      end else begin
        m_acc <= m_acc | pairs(m_s1_act, m_s1_la);
        m_cv  <= 1'b0;
      end
      if (fsync) for (int i = 0; i < N; i++) m_live[i] <= m_shadow[i];
      if (prio_wr_en && int'(prio_wr_idx) < N) m_shadow[prio_wr_idx] <= int'(prio_wr_rank);
      m_s1_act <= active_in; m_s1_fs <= fsync; m_s1_ovl <= ovl_en;
      m_s1_la <= layer_active; m_s1_lp <= layer_pixel; m_s1_op <= ovl_pixel;
    end
  end

  always @(posedge clk) begin
    #1;
    check("pixel_out", pixel_out, m_pix);
    check("active_out", active_out, m_act);
    check("coll_flags", coll_flags, m_flags);
    check("coll_valid", coll_valid, m_cv);
    check("blend_pixel_out", pixel_out_b, m_pixb);
    check("blend_active_out", active_out_b, m_act);
    check("blend_coll_flags", coll_flags_b, m_flags);
    check("blend_coll_valid", coll_valid_b, m_cv);
  end

  task automatic pulse_fsync();
    fsync = 1'b1;
    step(1);
    fsync = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; fsync = 1'b0; active_in = 1'b0; layer_active = '0;
    ovl_en = 1'b0; ovl_pixel = '0; prio_wr_en = 1'b0; prio_wr_idx = '0; prio_wr_rank = '0;
    layer_pixel = {C4, C3, C2, C1, C0};
    step(3);
    check("rst_pixel", pixel_out, 64'h0);
    check("rst_active", active_out, 64'h0);
    check("rst_flags", coll_flags, 64'h0);
    check("rst_valid", coll_valid, 64'h0);
    rst_n = 1'b1;
    step(4);

    // two-cycle latency, L2 in front of L4 with identity ranks
    active_in = 1'b1; layer_active = 5'b10100;
    step(1);
    check("t1_latency1", pixel_out, 64'h0);
    step(1);
    check("t1_l2", pixel_out, C2);
    check("t1_active", active_out, 64'h1);

    // rank writes wait for fsync; idx 7 ignored; write in fsync cycle waits a frame
    prio_wr_en = 1'b1; prio_wr_idx = 3'd4; prio_wr_rank = 3'd0;
    step(1);
    prio_wr_idx = 3'd7; prio_wr_rank = 3'd7;
    step(1);
    prio_wr_en = 1'b0;
    step(3);
    check("t2_hold", pixel_out, C2);
    fsync = 1'b1; prio_wr_en = 1'b1; prio_wr_idx = 3'd2; prio_wr_rank = 3'd0;
    step(1);
    fsync = 1'b0; prio_wr_en = 1'b0;
    step(3);
    check("t2_l4", pixel_out, C4);
    pulse_fsync();
    step(3);
    check("t2_tie_lower_idx", pixel_out, C2);

    // overlay with no layers, then blanking
    layer_active = '0; ovl_en = 1'b1; ovl_pixel = 24'hFF0000;
    step(2);
    check("t3_ovl", pixel_out, 64'hFF0000);
    active_in = 1'b0;
    step(2);
    check("t3_blank", pixel_out, 64'h0);
    check("t3_active", active_out, 64'h0);
    ovl_en = 1'b0; active_in = 1'b1;

    // single-pixel L0/L3 overlap
    pulse_fsync();
    step(3);
    layer_active = 5'b01001;
    step(1);
    layer_active = '0;
    step(2);
    pulse_fsync();
    step(1);
    check("t4_valid", coll_valid, 64'h1);
    check("t4_flags", coll_flags, 64'h0008008);
    step(1);
    check("t4_valid_pulse", coll_valid, 64'h0);
    step(3);
    pulse_fsync();
    step(1);
    check("t4_clear", coll_flags, 64'h0);

    // back-to-back fsync with L0/L1 overlapping
    layer_active = 5'b00011; fsync = 1'b1;
    step(2);
    fsync = 1'b0; layer_active = '0;
    step(1);
    check("t4_b2b_flags", coll_flags, 64'h22);
    check("t4_b2b_valid", coll_valid, 64'h1);

    // blend mode OR
    layer_active = 5'b00011;
    step(2);
    check("t5_blend", pixel_out_b, 64'h0000FF);
    check("t5_prio", pixel_out, C0);

    // reset mid-frame
    layer_active = 5'b10010;
    step(2);
    check("t6_pre_l4", pixel_out, C4);
    rst_n = 1'b0;
    #1;
    check("t6_rst_pixel", pixel_out, 64'h0);
    check("t6_rst_active", active_out, 64'h0);
    check("t6_rst_flags", coll_flags, 64'h0);
    check("t6_rst_valid", coll_valid, 64'h0);
    layer_active = '0;
    step(2);
    rst_n = 1'b1;
    step(4);
    pulse_fsync();
    step(1);
    check("t6_post_valid", coll_valid, 64'h1);
    check("t6_post_flags", coll_flags, 64'h0);
    layer_active = 5'b10010;
    step(2);
    check("t6_identity_l1", pixel_out, C1);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
